// File: rtl/xy_div_pkg.sv
// Shared definitions for the sequential divider: register map, CTRL/STATUS
// bit positions and the controller state encoding.
// Purely declarative, no logic.
package xy_div_pkg;

    localparam logic [2:0] ADDR_DIVIDEND  = 3'd0;
    localparam logic [2:0] ADDR_DIVISOR   = 3'd1;
    localparam logic [2:0] ADDR_QUOTIENT  = 3'd2;
    localparam logic [2:0] ADDR_REMAINDER = 3'd3;
    localparam logic [2:0] ADDR_CTRL      = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_SIGNED_BIT = 1;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_DIV0_BIT = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not go negative.
// Purely combinational, no backpressure.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Partial remainder is always < divisor, so the shifted value is < 2*divisor
    // and the restored/subtracted result always fits back into WIDTH bits.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, dvs_i};
        q_o     = (shifted >= {1'b0, dvs_i});
        rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/xy_divider_seq.sv
// Register-mapped sequential divider, one quotient bit per clock (restoring).
// Latency: WIDTH+1 cycles from accepted start to DONE; divide-by-zero in 1.
// A start while busy is dropped; operand registers are free to change mid-run.
module xy_divider_seq
    import xy_div_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               E,
    input  logic               W,
    input  logic               R,
    input  logic [2:0]         ADDR,
    input  logic [WIDTH-1:0]   D,
    output logic [2*WIDTH-1:0] OUT,
    output logic               BUSY,
    output logic               DONE
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dividend_q, divisor_q;
    logic [WIDTH-1:0]   quot_q, rem_q;
    logic               done_st_q, div0_q, done_pulse_q;
    logic               d0_pend_q;
    logic [WIDTH-1:0]   acc_q;      // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0]   prem_q;     // partial remainder magnitude
    logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
    logic               qneg_q, rneg_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] out_q;

    logic               wr_en, rd_en;
    logic               start_ok, start_calc, start_d0;
    logic               sgn_sel, dvd_neg, dvs_neg;
    logic [WIDTH-1:0]   dvd_abs, dvs_abs;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [2*WIDTH-1:0] rd_val;

    assign wr_en = E & W;
    assign rd_en = E & R;

    // A start is only taken when fully idle, including the divide-by-zero slot.
    assign start_ok   = wr_en && (ADDR == ADDR_CTRL) && D[CTRL_START_BIT]
                        && (state_q == S_IDLE) && !d0_pend_q;
    assign start_calc = start_ok && (divisor_q != '0);
    assign start_d0   = start_ok && (divisor_q == '0);

    assign sgn_sel = SIGNED_EN && D[CTRL_SIGNED_BIT];
    assign dvd_neg = sgn_sel && dividend_q[WIDTH-1];
    assign dvs_neg = sgn_sel && divisor_q[WIDTH-1];
    assign dvd_abs = dvd_neg ? -dividend_q : dividend_q;
    assign dvs_abs = dvs_neg ? -divisor_q  : divisor_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (prem_q),
        .bit_i (acc_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Controller state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: WIDTH calc cycles, then one cycle of sign fix-up.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_calc) state_d = S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read mux over pre-edge register values, zero-extended onto OUT.
    always_comb begin
        rd_val = '0;
        case (ADDR)
            ADDR_DIVIDEND:  rd_val[WIDTH-1:0] = dividend_q;
            ADDR_DIVISOR:   rd_val[WIDTH-1:0] = divisor_q;
            ADDR_QUOTIENT:  rd_val[WIDTH-1:0] = quot_q;
            ADDR_REMAINDER: rd_val[WIDTH-1:0] = rem_q;
            ADDR_STATUS: begin
                rd_val[STAT_BUSY_BIT] = (state_q != S_IDLE);
                rd_val[STAT_DONE_BIT] = done_st_q;
                rd_val[STAT_DIV0_BIT] = div0_q;
            end
            default:        rd_val = '0;
        endcase
    end

    // Register file, operand capture, iteration datapath and result commit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dividend_q   <= '0;
            divisor_q    <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
            done_st_q    <= 1'b0;
            div0_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            d0_pend_q    <= 1'b0;
            acc_q        <= '0;
            prem_q       <= '0;
            dvs_q        <= '0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            cnt_q        <= '0;
            out_q        <= '0;
        end else begin
            done_pulse_q <= 1'b0;

            if (rd_en) out_q <= rd_val;

            if (wr_en && ADDR == ADDR_DIVIDEND) dividend_q <= D;
            if (wr_en && ADDR == ADDR_DIVISOR)  divisor_q  <= D;

            if (start_ok) begin
                done_st_q <= 1'b0;
                div0_q    <= 1'b0;
            end

            if (start_calc) begin
                acc_q  <= dvd_abs;
                dvs_q  <= dvs_abs;
                prem_q <= '0;
                cnt_q  <= CW'(WIDTH - 1);
                qneg_q <= dvd_neg ^ dvs_neg;
                rneg_q <= dvd_neg;
            end

            // Divide-by-zero: the captured dividend waits one cycle in acc_q.
            if (start_d0) begin
                d0_pend_q <= 1'b1;
                acc_q     <= dividend_q;
            end

            if (d0_pend_q) begin
                d0_pend_q    <= 1'b0;
                quot_q       <= '1;
                rem_q        <= acc_q;
                div0_q       <= 1'b1;
                done_st_q    <= 1'b1;
                done_pulse_q <= 1'b1;
            end

            if (state_q == S_CALC) begin
                prem_q <= step_rem;
                acc_q  <= {acc_q[WIDTH-2:0], step_q};
                cnt_q  <= cnt_q - CW'(1);
            end

            // Negating the quotient magnitude wraps naturally for MIN / -1.
            if (state_q == S_FIX) begin
                quot_q       <= qneg_q ? -acc_q  : acc_q;
                rem_q        <= rneg_q ? -prem_q : prem_q;
                done_st_q    <= 1'b1;
                done_pulse_q <= 1'b1;
            end
        end
    end

    assign OUT  = out_q;
    assign BUSY = (state_q != S_IDLE);
    assign DONE = done_pulse_q;

endmodule

// File: tb/tb_xy_divider_seq.sv
// Self-checking bench for xy_divider_seq (WIDTH=16, SIGNED_EN=1): bus tasks,
// a reference division model and a queue of expected results that is drained
// when the DUT signals DONE.
module tb_xy_divider_seq;

    localparam logic [2:0] A_DVD  = 3'd0;
    localparam logic [2:0] A_DVS  = 3'd1;
    localparam logic [2:0] A_QUO  = 3'd2;
    localparam logic [2:0] A_REM  = 3'd3;
    localparam logic [2:0] A_CTRL = 3'd4;
    localparam logic [2:0] A_STAT = 3'd5;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic [2:0]  st;
        int          lat;
        int          busy;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        E = 1'b0, W = 1'b0, R = 1'b0;
    logic [2:0]  ADDR = 3'd0;
    logic [15:0] D = 16'd0;
    logic [31:0] OUT;
    logic        BUSY, DONE;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb[$];

    xy_divider_seq #(.WIDTH(16), .SIGNED_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST), .E(E), .W(W), .R(R),
        .ADDR(ADDR), .D(D), .OUT(OUT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; the access happens on the following posedge.
    task automatic access(input logic w, input logic r, input logic [2:0] a, input logic [15:0] d);
        E = 1'b1; W = w; R = r; ADDR = a; D = d;
        @(negedge CLK);
        E = 1'b0; W = 1'b0; R = 1'b0;
    endtask

    // Counts negedges from the start edge until DONE, tallying BUSY samples.
    task automatic wait_done(input int n0, output int n, output int busy_cnt);
        n = n0;
        busy_cnt = 0;
        while (n < 200) begin
            if (BUSY) busy_cnt++;
            @(negedge CLK);
            n++;
            if (DONE) break;
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                  output logic [15:0] q, output logic [15:0] r, output logic d0);
        int sa, sbv, qi, ri;
        d0 = 1'b0;
        if (b == 16'd0) begin
            q = 16'hFFFF; r = a; d0 = 1'b1;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else begin
            sa  = int'($signed(a));
            sbv = int'($signed(b));
            qi  = sa / sbv;
            ri  = sa % sbv;
            q   = qi[15:0];
            r   = ri[15:0];
        end
    endfunction

    task automatic run_op(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                          input logic sgn, input logic [15:0] eq, input logic [15:0] er,
                          input logic ediv0);
        exp_t e;
        int   n, b;
        access(1'b1, 1'b0, A_DVD, dvd);
        access(1'b1, 1'b0, A_DVS, dvs);
        e.q    = eq;
        e.r    = er;
        e.st   = ediv0 ? 3'b110 : 3'b010;
        e.lat  = ediv0 ? 1 : 17;
        e.busy = ediv0 ? 0 : 17;
        sb.push_back(e);
        access(1'b1, 1'b0, A_CTRL, {14'd0, sgn, 1'b1});
        wait_done(0, n, b);
        chk({tag, "_done_seen"}, {31'd0, DONE}, 32'd1);
        e = sb.pop_front();
        chk({tag, "_latency"}, n, e.lat);
        chk({tag, "_busy_cycles"}, b, e.busy);
        access(1'b0, 1'b1, A_QUO, 16'd0);
        chk({tag, "_done_pulse_1cyc"}, {31'd0, DONE}, 32'd0);
        chk({tag, "_quotient"}, OUT, {16'd0, e.q});
        access(1'b0, 1'b1, A_REM, 16'd0);
        chk({tag, "_remainder"}, OUT, {16'd0, e.r});
        access(1'b0, 1'b1, A_STAT, 16'd0);
        chk({tag, "_status"}, OUT, {29'd0, e.st});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] a, b, q, r;
        logic        d0, s;
        exp_t        e;
        int          n, bc, seen;

        repeat (3) @(negedge CLK);
        chk("rst_out", OUT, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        RST = 1'b0;

        access(1'b0, 1'b1, A_STAT, 16'd0);
        chk("rst_status", OUT, 32'd0);
        access(1'b0, 1'b1, A_QUO, 16'd0);
        chk("rst_quotient", OUT, 32'd0);

        // Register access behaviour.
        access(1'b1, 1'b0, A_DVD, 16'h1234);
        access(1'b1, 1'b1, A_DVD, 16'h5678);
        chk("rw_same_addr_old", OUT, 32'h0000_1234);
        access(1'b0, 1'b1, A_DVD, 16'd0);
        chk("dividend_rb", OUT, 32'h0000_5678);
        access(1'b1, 1'b0, 3'd6, 16'hBEEF);
        access(1'b0, 1'b1, 3'd6, 16'd0);
        chk("reserved_rd0", OUT, 32'd0);
        access(1'b1, 1'b0, A_QUO, 16'hBEEF);
        access(1'b0, 1'b1, A_QUO, 16'd0);
        chk("ro_quotient", OUT, 32'd0);

        // Directed cases with hand-derived results.
        run_op("u100_7",   16'd100,   16'd7,     1'b0, 16'd14,    16'd2,     1'b0);
        run_op("u_ffff",   16'hFFFF,  16'hFFFF,  1'b0, 16'd1,     16'd0,     1'b0);
        run_op("u2_4",     16'd2,     16'd4,     1'b0, 16'd0,     16'd2,     1'b0);
        run_op("s_m7_2",   16'hFFF9,  16'd2,     1'b1, 16'hFFFD,  16'hFFFF,  1'b0);
        run_op("s_7_m2",   16'd7,     16'hFFFE,  1'b1, 16'hFFFD,  16'd1,     1'b0);
        run_op("s_ovf",    16'h8000,  16'hFFFF,  1'b1, 16'h8000,  16'd0,     1'b0);
        run_op("u_8000",   16'h8000,  16'hFFFF,  1'b0, 16'd0,     16'h8000,  1'b0);
        run_op("div0",     16'd55,    16'd0,     1'b0, 16'hFFFF,  16'd55,    1'b1);

        // Operand writes and a second start during a running division.
        access(1'b1, 1'b0, A_DVD, 16'd100);
        access(1'b1, 1'b0, A_DVS, 16'd7);
        e.q = 16'd14; e.r = 16'd2; e.st = 3'b010; e.lat = 17; e.busy = 17;
        sb.push_back(e);
        access(1'b1, 1'b0, A_CTRL, 16'd1);
        repeat (4) @(negedge CLK);
        access(1'b1, 1'b0, A_DVS, 16'd1);
        access(1'b1, 1'b0, A_CTRL, 16'd1);
        access(1'b0, 1'b1, A_STAT, 16'd0);
        chk("midrun_status", OUT, 32'd1);
        wait_done(7, n, bc);
        e = sb.pop_front();
        chk("midrun_latency", n, e.lat);
        access(1'b0, 1'b1, A_QUO, 16'd0);
        chk("midrun_quotient", OUT, {16'd0, e.q});
        access(1'b0, 1'b1, A_REM, 16'd0);
        chk("midrun_remainder", OUT, {16'd0, e.r});
        access(1'b0, 1'b1, A_DVS, 16'd0);
        chk("midrun_divisor_rb", OUT, 32'd1);

        // Reset in the middle of a division.
        access(1'b1, 1'b0, A_DVD, 16'd1000);
        access(1'b1, 1'b0, A_DVS, 16'd3);
        access(1'b0, 1'b1, A_DVD, 16'd0);
        access(1'b1, 1'b0, A_CTRL, 16'd1);
        repeat (7) @(negedge CLK);
        @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, BUSY}, 32'd0);
        chk("midrst_out", OUT, 32'd0);
        chk("midrst_done", {31'd0, DONE}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge CLK);
            if (DONE) seen = 1;
        end
        chk("midrst_no_done", seen, 0);
        access(1'b0, 1'b1, A_QUO, 16'd0);
        chk("midrst_quotient", OUT, 32'd0);
        access(1'b0, 1'b1, A_STAT, 16'd0);
        chk("midrst_status", OUT, 32'd0);
        run_op("post_rst", 16'd500, 16'd9, 1'b0, 16'd55, 16'd5, 1'b0);

        // Random operands checked against the reference model.
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom);
            b = (i < 4) ? 16'($urandom_range(0, 300)) : 16'($urandom);
            s = i[0];
            model(a, b, s, q, r, d0);
            run_op("rand", a, b, s, q, r, d0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/xy_divider_seq.md
XY_DIVIDER_SEQ -- requirements
Module: xy_divider_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits (legal 4..32).
REQ-002 Parameter SIGNED_EN, default 1; 1 = signed mode selectable via CTRL, 0 = CTRL.signed ignored (always unsigned).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 E  input  1  access enable; W and R take effect only when E=1.
REQ-006 W  input  1  register write strobe.
REQ-007 R  input  1  register read strobe.
REQ-008 ADDR  input  3  register address.
REQ-009 D  input  WIDTH  write data.
REQ-010 OUT  output  2*WIDTH  registered read data, zero-extended.
REQ-011 BUSY  output  1  high while a division is in progress.
REQ-012 DONE  output  1  one-cycle pulse when results become valid.

Function
REQ-013 Register map: 0 DIVIDEND (rw), 1 DIVISOR (rw), 2 QUOTIENT (ro), 3 REMAINDER (ro), 4 CTRL (wo: bit0 start, bit1 signed), 5 STATUS (ro: bit0 busy, bit1 done, bit2 div0), 6-7 reserved (read 0, write ignored).
REQ-014 Write: on CLK edge with E=1, W=1, D is stored to the addressed writable register; writes to read-only/reserved addresses have no effect.
REQ-015 Read: on CLK edge with E=1, R=1, OUT loads the addressed register's pre-edge value; otherwise OUT holds.
REQ-016 Simultaneous W and R to the same address: OUT returns the old value.
REQ-017 Start: CTRL write with bit0=1 while IDLE latches DIVIDEND, DIVISOR and signed mode into internal operands; start while BUSY is ignored.
REQ-018 Later writes to DIVIDEND/DIVISOR do not affect an operation in progress.
REQ-019 FSM states IDLE, CALC, FIX; IDLE->CALC on start with nonzero divisor; CALC iterates exactly WIDTH cycles (one restoring quotient bit per cycle, MSB first); CALC->FIX after last bit; FIX->IDLE after one cycle.
REQ-020 Latency: start accepted at edge k; BUSY=1 from edge k to edge k+WIDTH+1; QUOTIENT/REMAINDER update and DONE pulses at edge k+WIDTH+1.
REQ-021 Divide by zero: start with DIVISOR=0 stays IDLE, at edge k+1 sets QUOTIENT all ones, REMAINDER=DIVIDEND, STATUS.div0=1, pulses DONE; BUSY never asserts.
REQ-022 Signed mode: operands two's complement; magnitudes divided; quotient truncates toward zero; remainder takes dividend sign; FIX applies sign correction.
REQ-023 Signed overflow (-2^(WIDTH-1) / -1): QUOTIENT = -2^(WIDTH-1) (wrap), REMAINDER=0, div0=0.
REQ-024 STATUS.done is sticky, set with DONE, cleared by next accepted start; div0 cleared by next accepted start.
REQ-025 Invariant (non-div0): DIVIDEND == QUOTIENT*DIVISOR + REMAINDER, |REMAINDER| < |DIVISOR|, truncated to WIDTH bits.

Reset
REQ-026 RST asserted asynchronously forces IDLE; OUT, BUSY, DONE, all registers and STATUS to 0.
REQ-027 RST mid-operation aborts the division; no DONE pulse is produced and results remain 0.
REQ-028 First accepted access occurs at the first rising CLK edge after RST deasserts.

Structure
REQ-029 Shared package xy_div_pkg holds address constants, CTRL/STATUS bit indices and the FSM state type.
REQ-030 One sub-module div_step: combinational single restoring iteration (partial remainder, divisor -> next remainder, quotient bit), instantiated once.

Verification
REQ-031 Unsigned WIDTH=16: DIVIDEND=100, DIVISOR=7, start -> DONE at k+17, QUOTIENT=14, REMAINDER=2, BUSY high 17 cycles.
REQ-032 Unsigned 65535/65535 -> QUOTIENT=1, REMAINDER=0; 2/4 -> QUOTIENT=0, REMAINDER=2.
REQ-033 Signed -7/2 -> QUOTIENT=0xFFFD (-3), REMAINDER=0xFFFF (-1); 0x8000/0xFFFF -> QUOTIENT=0x8000, REMAINDER=0.
REQ-034 DIVISOR=0, DIVIDEND=55, start -> DONE at k+1, QUOTIENT=0xFFFF, REMAINDER=55, STATUS=0b110, BUSY stays 0.
REQ-035 Start, then at k+5 write DIVISOR=1 and CTRL start again -> ignored; original result delivered at k+17; DIVISOR reads 1.
REQ-036 Assert RST at k+8 -> BUSY=0, OUT=0 immediately, no DONE; subsequent start with new operands completes correctly.
